// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array output path: default geometry, drain FSM
// encoding and the column-slice helper for packed per-column buses.
package pe_array_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_COLS   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // LSB of column `col` on a bus that packs `width`-bit words side by side.
    function automatic int col_lsb(input int col, input int width);
        return col * width;
    endfunction

endpackage

// File: rtl/psum_row_bank.sv
// One row buffer: NUM_COLS words, per-column arrival mask and a full flag.
// Writes land at the edge; the read port is a plain mux over the stored words.
module psum_row_bank
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    parameter int CIDX_W     = $clog2(NUM_COLS)
) (
    input  logic                           i_clk,
    input  logic                           i_rest,
    input  logic [NUM_COLS-1:0]            i_wr_en,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] i_wr_data,
    input  logic                           i_set_full,
    input  logic                           i_clr_full,
    input  logic [CIDX_W-1:0]              i_rd_idx,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic [NUM_COLS-1:0]            o_mask,
    output logic                           o_full
);

    logic [DATA_WIDTH-1:0] data_q [NUM_COLS];
    logic [DATA_WIDTH-1:0] data_d [NUM_COLS];
    logic [NUM_COLS-1:0]   mask_q, mask_d;
    logic                  full_q, full_d;

    always_comb begin
        data_d = data_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (i_wr_en[c]) begin
                data_d[c] = i_wr_data[col_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        // Completing the row hands the mask back clean for the next fill.
        mask_d = i_set_full ? '0 : (mask_q | i_wr_en);
        full_d = full_q;
        if (i_set_full) full_d = 1'b1;
        if (i_clr_full) full_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            mask_q <= '0;
            full_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_rd_data = data_q[i_rd_idx];
    assign o_mask    = mask_q;
    assign o_full    = full_q;

endmodule

// File: rtl/psum_row_collector.sv
// Collects skewed per-column psum words into rows in a ping-pong bank pair and
// streams completed rows out word by word over valid/ready.
module psum_row_collector
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    parameter int ROW_IDX_W  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rest,
    input  logic [NUM_COLS-1:0]            i_col_valid,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] i_psum_f_pe,
    output logic                           o_array_stall,
    output logic [DATA_WIDTH-1:0]          o_psum_data,
    output logic                           o_psum_valid,
    input  logic                           i_psum_ready,
    output logic                           o_psum_last,
    output logic [ROW_IDX_W-1:0]           o_row_idx,
    output logic                           o_overflow,
    input  logic                           i_clear_err
);

    localparam int                CIDX_W   = $clog2(NUM_COLS);
    localparam logic [CIDX_W-1:0] LAST_COL = CIDX_W'(NUM_COLS - 1);

    drain_state_e         state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [CIDX_W-1:0]    col_idx_q, col_idx_d;
    logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
    logic                 overflow_q, overflow_d;

    logic [NUM_COLS-1:0]   bank_mask    [2];
    logic [DATA_WIDTH-1:0] bank_rd_data [2];
    logic [NUM_COLS-1:0]   bank_wr_en   [2];
    logic [1:0]            bank_full;
    logic [1:0]            bank_set_full;
    logic [1:0]            bank_clr_full;

    logic [NUM_COLS-1:0] cur_mask, accepted;
    logic                cur_full, row_done, ovf_event, row_release;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        psum_row_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_COLS   (NUM_COLS),
            .CIDX_W     (CIDX_W)
        ) u_bank (
            .i_clk      (i_clk),
            .i_rest     (i_rest),
            .i_wr_en    (bank_wr_en[b]),
            .i_wr_data  (i_psum_f_pe),
            .i_set_full (bank_set_full[b]),
            .i_clr_full (bank_clr_full[b]),
            .i_rd_idx   (col_idx_q),
            .o_rd_data  (bank_rd_data[b]),
            .o_mask     (bank_mask[b]),
            .o_full     (bank_full[b])
        );
    end

    // Capture side: a full write bank swallows every valid as an overflow.
    always_comb begin
        cur_mask   = bank_mask[wr_bank_q];
        cur_full   = bank_full[wr_bank_q];
        accepted   = cur_full ? '0 : (i_col_valid & ~cur_mask);
        row_done   = (|accepted) && (&(cur_mask | accepted));
        ovf_event  = cur_full ? (|i_col_valid) : (|(i_col_valid & cur_mask));
        wr_bank_d  = wr_bank_q ^ row_done;
        overflow_d = (overflow_q & ~i_clear_err) | ovf_event;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_wr_en[b]    = (wr_bank_q == 1'(b)) ? accepted : '0;
            bank_set_full[b] = row_done && (wr_bank_q == 1'(b));
            bank_clr_full[b] = row_release && (rd_bank_q == 1'(b));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            col_idx_q  <= '0;
            row_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        rd_bank_d   = rd_bank_q;
        row_idx_d   = row_idx_q;
        row_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full[rd_bank_q]) begin
                    state_d   = DRAIN;
                    col_idx_d = '0;
                end
            end
            DRAIN: begin
                if (i_psum_ready) begin
                    if (col_idx_q == LAST_COL) begin
                        row_release = 1'b1;
                        col_idx_d   = '0;
                        rd_bank_d   = ~rd_bank_q;
                        row_idx_d   = row_idx_q + 1'b1;
                        // Other bank already waiting: keep streaming without a bubble.
                        state_d     = bank_full[~rd_bank_q] ? DRAIN : IDLE;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        o_psum_valid = (state_q == DRAIN);
        o_psum_data  = '0;
        o_psum_last  = 1'b0;
        if (state_q == DRAIN) begin
            o_psum_data = bank_rd_data[rd_bank_q];
            o_psum_last = (col_idx_q == LAST_COL);
        end
    end

    assign o_array_stall = bank_full[wr_bank_q];
    assign o_row_idx     = row_idx_q;
    assign o_overflow    = overflow_q;

endmodule
